// File: rtl/ritc_phase_scan_engine.sv
// ritc_phase_scan_engine
//
// Sweeps the MMCM fine phase one step at a time. For each step it issues a
// single PSEN pulse, waits for PSDONE (bounded by PS_TIMEOUT cycles), idles
// for a programmable settle time, then counts the ones seen on each RITC's
// scan bit over a programmable number of samples. Each completed step is
// reported through a one-cycle result strobe. The first 0->1 transition of
// the per-RITC majority bit across steps is recorded as that RITC's edge.
//
// Ports
//   user_clk_i, user_rst_n_i : clock, async active-low reset
//   start_i, abort_i         : one-cycle sweep request / abort request
//   dir_i, nsteps_i,
//   nsamp_i, settle_i        : sweep configuration, latched on start
//   PSEN, PSINCDEC, PSDONE   : MMCM dynamic phase-shift handshake
//   scan_bit_i               : one registered scan bit per RITC
//   busy_o, done_o,
//   timeout_o                : sweep status
//   res_wr_o, res_step_o,
//   res_cnt_o                : per-step result strobe, step index, counts
//   edge_valid_o, edge_pos_o : first rising edge found per RITC
//
// Phase-shift handshake: PSEN is high for exactly one cycle per step; the
// engine then waits for a single-cycle PSDONE before sampling. A shift that
// has been requested is always waited out, even when an abort arrives.

module ritc_phase_scan_engine #(
  parameter int NUM_RITC   = 2,
  parameter int STEP_W     = 10,
  parameter int SAMP_W     = 4,
  parameter int PS_TIMEOUT = 1023
) (
  input  logic                         user_clk_i,
  input  logic                         user_rst_n_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         dir_i,
  input  logic [STEP_W-1:0]            nsteps_i,
  input  logic [SAMP_W-1:0]            nsamp_i,
  input  logic [3:0]                   settle_i,
  output logic                         PSEN,
  output logic                         PSINCDEC,
  input  logic                         PSDONE,
  input  logic [NUM_RITC-1:0]          scan_bit_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         timeout_o,
  output logic                         res_wr_o,
  output logic [STEP_W-1:0]            res_step_o,
  output logic [NUM_RITC*SAMP_W-1:0]   res_cnt_o,
  output logic [NUM_RITC-1:0]          edge_valid_o,
  output logic [NUM_RITC*STEP_W-1:0]   edge_pos_o
);

  localparam int TO_W  = $clog2(PS_TIMEOUT + 1);
  localparam int CNT_W = NUM_RITC * SAMP_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_WAIT_DONE,
    S_SETTLE,
    S_SAMPLE,
    S_REPORT,
    S_FINISH
  } state_t;

  state_t                     state_q, state_d;
  logic                       dir_q;
  logic [STEP_W-1:0]          nsteps_q;
  logic [SAMP_W-1:0]          nsamp_q;      // effective count, never 0
  logic [3:0]                 settle_q;
  logic [STEP_W-1:0]          step_q;
  logic [TO_W-1:0]            wait_q;
  logic [3:0]                 settle_cnt_q;
  logic [SAMP_W-1:0]          samp_q;
  logic                       abort_pend_q;
  logic                       timeout_q;
  logic [STEP_W-1:0]          res_step_q;
  logic [CNT_W-1:0]           res_cnt_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [NUM_RITC-1:0]        prev_maj_q;
  logic [NUM_RITC-1:0]        edge_valid_q;
  logic [NUM_RITC*STEP_W-1:0] edge_pos_q;

  logic                       psen_d;
  logic [CNT_W-1:0]           cnt_nxt;
  logic [NUM_RITC-1:0]        maj;
  logic                       wait_expired;
  logic                       samp_last;
  logic                       settle_last;
  logic                       last_step;
  logic                       start_ok;

  // wait_q is loaded with 1 during the PSEN cycle, so it equals the number
  // of cycles elapsed since PSEN; the timeout lands exactly PS_TIMEOUT
  // cycles after the PSEN pulse.
  assign wait_expired = (wait_q == TO_W'(PS_TIMEOUT - 1));
  assign samp_last    = (samp_q == nsamp_q - SAMP_W'(1));
  assign settle_last  = (settle_cnt_q == settle_q - 4'd1);
  assign last_step    = ((step_q + STEP_W'(1)) == nsteps_q);
  // Abort has priority over a simultaneous start.
  assign start_ok     = (state_q == S_IDLE) && start_i && !abort_i;

  // Saturating ones-counters and majority decision.
  always_comb begin
    cnt_nxt = cnt_q;
    maj     = '0;
    for (int k = 0; k < NUM_RITC; k++) begin
      if (scan_bit_i[k] && (cnt_q[k*SAMP_W +: SAMP_W] != {SAMP_W{1'b1}})) begin
        cnt_nxt[k*SAMP_W +: SAMP_W] = cnt_q[k*SAMP_W +: SAMP_W] + SAMP_W'(1);
      end
      maj[k] = ({res_cnt_q[k*SAMP_W +: SAMP_W], 1'b0} > {1'b0, nsamp_q});
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    psen_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = (nsteps_i == '0) ? S_FINISH : S_STEP;
        end
      end
      S_STEP: begin
        // An abort here suppresses the pulse, so no shift is left dangling.
        if (abort_i) begin
          state_d = S_FINISH;
        end else begin
          psen_d  = 1'b1;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (PSDONE) begin
          if (abort_pend_q || abort_i) begin
            state_d = S_FINISH;
          end else if (settle_q == 4'd0) begin
            state_d = S_SAMPLE;
          end else begin
            state_d = S_SETTLE;
          end
        end else if (wait_expired) begin
          state_d = S_FINISH;
        end
      end
      S_SETTLE: begin
        if (abort_i) begin
          state_d = S_FINISH;
        end else if (settle_last) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort_i) begin
          state_d = S_FINISH;
        end else if (samp_last) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        if (abort_i || last_step) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_STEP;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
    if (!user_rst_n_i) begin
      state_q      <= S_IDLE;
      dir_q        <= 1'b0;
      nsteps_q     <= '0;
      nsamp_q      <= '0;
      settle_q     <= '0;
      step_q       <= '0;
      wait_q       <= '0;
      settle_cnt_q <= '0;
      samp_q       <= '0;
      abort_pend_q <= 1'b0;
      timeout_q    <= 1'b0;
      res_step_q   <= '0;
      res_cnt_q    <= '0;
      cnt_q        <= '0;
      prev_maj_q   <= '0;
      edge_valid_q <= '0;
      edge_pos_q   <= '0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        dir_q        <= dir_i;
        nsteps_q     <= nsteps_i;
        nsamp_q      <= (nsamp_i == '0) ? SAMP_W'(1) : nsamp_i;
        settle_q     <= settle_i;
        step_q       <= '0;
        timeout_q    <= 1'b0;
        edge_valid_q <= '0;
        edge_pos_q   <= '0;
        prev_maj_q   <= '0;
      end

      if (state_q == S_STEP) begin
        wait_q <= TO_W'(1);
      end else if (state_q == S_WAIT_DONE) begin
        wait_q <= wait_q + TO_W'(1);
      end

      if ((state_q == S_WAIT_DONE) && !PSDONE && wait_expired) begin
        timeout_q <= 1'b1;
      end

      // Abort seen while a shift is outstanding is held until it completes.
      abort_pend_q <= (state_q == S_WAIT_DONE) && (abort_pend_q || abort_i);

      settle_cnt_q <= (state_q == S_SETTLE) ? settle_cnt_q + 4'd1 : 4'd0;

      // Counters are cleared on the way into SAMPLE (end of settle).
      if ((state_d == S_SAMPLE) && (state_q != S_SAMPLE)) begin
        cnt_q  <= '0;
        samp_q <= '0;
      end else if (state_q == S_SAMPLE) begin
        cnt_q  <= cnt_nxt;
        samp_q <= samp_q + SAMP_W'(1);
        // Result registers load only when a REPORT follows, so they hold
        // the previous report through an aborted step.
        if (state_d == S_REPORT) begin
          res_cnt_q  <= cnt_nxt;
          res_step_q <= step_q;
        end
      end

      if (state_q == S_REPORT) begin
        prev_maj_q <= maj;
        for (int k = 0; k < NUM_RITC; k++) begin
          if ((step_q != '0) && !prev_maj_q[k] && maj[k] && !edge_valid_q[k]) begin
            edge_valid_q[k]                  <= 1'b1;
            edge_pos_q[k*STEP_W +: STEP_W]   <= step_q;
          end
        end
        if (state_d == S_STEP) begin
          step_q <= step_q + STEP_W'(1);
        end
      end
    end
  end

  assign PSEN         = psen_d;
  assign PSINCDEC     = dir_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_FINISH);
  assign timeout_o    = timeout_q;
  assign res_wr_o     = (state_q == S_REPORT);
  assign res_step_o   = res_step_q;
  assign res_cnt_o    = res_cnt_q;
  assign edge_valid_o = edge_valid_q;
  assign edge_pos_o   = edge_pos_q;

endmodule

// File: tb/tb_ritc_phase_scan_engine.sv
// Directed bench for ritc_phase_scan_engine. A responder process answers
// every PSEN with a PSDONE a fixed number of cycles later and drives the
// scan bits per step; a monitor logs pulses and result strobes; the main
// sequence runs each scenario and compares against hand-computed values.

module tb_ritc_phase_scan_engine;

  localparam int NUM_RITC   = 2;
  localparam int STEP_W     = 10;
  localparam int SAMP_W     = 4;
  localparam int PS_TIMEOUT = 1023;
  localparam int CNT_W      = NUM_RITC * SAMP_W;
  localparam int RES_W      = STEP_W + CNT_W;

  logic                       clk;
  logic                       rst_n;
  logic                       start;
  logic                       abort;
  logic                       dir;
  logic [STEP_W-1:0]          nsteps;
  logic [SAMP_W-1:0]          nsamp;
  logic [3:0]                 settle;
  logic                       psen;
  logic                       psincdec;
  logic                       psdone;
  logic [NUM_RITC-1:0]        scan_bit;
  logic                       busy;
  logic                       done;
  logic                       timeout;
  logic                       res_wr;
  logic [STEP_W-1:0]          res_step;
  logic [CNT_W-1:0]           res_cnt;
  logic [NUM_RITC-1:0]        edge_valid;
  logic [NUM_RITC*STEP_W-1:0] edge_pos;

  ritc_phase_scan_engine #(
    .NUM_RITC  (NUM_RITC),
    .STEP_W    (STEP_W),
    .SAMP_W    (SAMP_W),
    .PS_TIMEOUT(PS_TIMEOUT)
  ) dut (
    .user_clk_i  (clk),
    .user_rst_n_i(rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .dir_i       (dir),
    .nsteps_i    (nsteps),
    .nsamp_i     (nsamp),
    .settle_i    (settle),
    .PSEN        (psen),
    .PSINCDEC    (psincdec),
    .PSDONE      (psdone),
    .scan_bit_i  (scan_bit),
    .busy_o      (busy),
    .done_o      (done),
    .timeout_o   (timeout),
    .res_wr_o    (res_wr),
    .res_step_o  (res_step),
    .res_cnt_o   (res_cnt),
    .edge_valid_o(edge_valid),
    .edge_pos_o  (edge_pos)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  int               psen_total = 0;
  int               done_total = 0;
  int               res_total  = 0;
  int               psen_cyc   = 0;
  int               done_cyc   = 0;
  int               to_cyc     = 0;
  logic             to_prev    = 1'b0;
  logic [RES_W-1:0] res_log [0:31];

  always @(negedge clk) begin
    if (psen) begin
      psen_total <= psen_total + 1;
      psen_cyc   <= cyc;
    end
    if (done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
    if (res_wr) begin
      res_log[5'(res_total)] <= {res_step, res_cnt};
      res_total              <= res_total + 1;
    end
    if (timeout && !to_prev) to_cyc <= cyc;
    to_prev <= timeout;
  end

  // ---------------- PSDONE / scan-bit responder ----------------
  // mode 0: bits 0; mode 1: RITC0 = (step >= 2), RITC1 = step[0]; mode 2: bits 1
  int resp_total = 0;
  int resp_base  = 0;
  int scan_mode  = 0;
  int ps_delay   = 5;
  bit psdone_en  = 1'b1;

  initial begin
    int s;
    psdone   = 1'b0;
    scan_bit = '0;
    forever begin
      @(negedge clk);
      if (psen) begin
        s = resp_total - resp_base;
        resp_total = resp_total + 1;
        case (scan_mode)
          1:       scan_bit = {1'(s % 2), 1'(s >= 2)};
          2:       scan_bit = '1;
          default: scan_bit = '0;
        endcase
        if (psdone_en) begin
          repeat (ps_delay) @(negedge clk);
          psdone = 1'b1;
          @(negedge clk);
          psdone = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int               total = 0;
  int               bad   = 0;
  int               b_psen, b_done, b_res;
  logic [RES_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input int step, input int cnt);
    exp_q.push_back({STEP_W'(step), CNT_W'(cnt)});
  endtask

  task automatic check_results(input string tag, input int n);
    logic [RES_W-1:0] e;
    check({tag, "_nres"}, 64'(res_total - b_res), 64'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_res%0d", tag, i), 64'(res_log[5'(b_res + i)]), 64'(e));
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_sweep(input logic d, input int ns, input int nsm, input int st);
    @(negedge clk);
    b_psen    = psen_total;
    b_done    = done_total;
    b_res     = res_total;
    resp_base = resp_total;
    dir       = d;
    nsteps    = STEP_W'(ns);
    nsamp     = SAMP_W'(nsm);
    settle    = 4'(st);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_total != b_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({tag, "_done_wait"}, 64'(0), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_psen(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (psen) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({tag, "_psen_wait"}, 64'(0), 64'(1));
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, timeout, res_wr, psen, psincdec,
                res_step, res_cnt, edge_valid, edge_pos});
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    dir    = 1'b0;
    nsteps = '0;
    nsamp  = '0;
    settle = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sweep, scan bits 0; a start while busy must be ignored.
    scan_mode = 0;
    start_sweep(1'b1, 4, 3, 2);
    repeat (3) @(negedge clk);
    check("t1_busy", 64'(busy), 64'(1));
    nsteps = STEP_W'(7);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done("t1", 500);
    check("t1_npsen", 64'(psen_total - b_psen), 64'(4));
    check("t1_ndone", 64'(done_total - b_done), 64'(1));
    for (int i = 0; i < 4; i++) expect_res(i, 0);
    check_results("t1", 4);
    check("t1_edge_valid", 64'(edge_valid), 64'(0));
    check("t1_psincdec", 64'(psincdec), 64'(1));
    check("t1_busy_end", 64'(busy), 64'(0));
    check("t1_timeout", 64'(timeout), 64'(0));

    // Edge detection: RITC0 rises at step 2, RITC1 rises at 1 then again at 3.
    scan_mode = 1;
    start_sweep(1'b0, 4, 4, 0);
    wait_done("t2", 500);
    expect_res(0, 'h00);
    expect_res(1, 'h40);
    expect_res(2, 'h04);
    expect_res(3, 'h44);
    check_results("t2", 4);
    check("t2_edge_valid", 64'(edge_valid), 64'(2'b11));
    check("t2_edge_pos0", 64'(edge_pos[STEP_W-1:0]), 64'(2));
    check("t2_edge_pos1", 64'(edge_pos[2*STEP_W-1:STEP_W]), 64'(1));
    check("t2_psincdec", 64'(psincdec), 64'(0));
    check("t2_cnt_hold", 64'(res_cnt), 64'(8'h44));
    check("t2_step_hold", 64'(res_step), 64'(3));

    // PSDONE never arrives.
    psdone_en = 1'b0;
    start_sweep(1'b1, 3, 2, 1);
    wait_done("t3", 3000);
    check("t3_timeout", 64'(timeout), 64'(1));
    check("t3_timeout_lat", 64'(to_cyc - psen_cyc), 64'(PS_TIMEOUT));
    check("t3_npsen", 64'(psen_total - b_psen), 64'(1));
    check("t3_ndone", 64'(done_total - b_done), 64'(1));
    check("t3_nres", 64'(res_total - b_res), 64'(0));
    check("t3_edge_cleared", 64'({edge_valid, edge_pos}), 64'(0));

    // Abort while waiting for PSDONE; PSDONE arrives 3 cycles after abort.
    psdone_en = 1'b1;
    scan_mode = 0;
    start_sweep(1'b1, 3, 2, 1);
    wait_psen("t4", 50);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done("t4", 200);
    check("t4_timeout_cleared", 64'(timeout), 64'(0));
    check("t4_npsen", 64'(psen_total - b_psen), 64'(1));
    check("t4_done_lat", 64'(done_cyc - psen_cyc), 64'(6));
    check("t4_nres", 64'(res_total - b_res), 64'(0));
    check("t4_busy_end", 64'(busy), 64'(0));

    // Start and abort together in IDLE: stay idle.
    @(negedge clk);
    b_psen = psen_total;
    b_done = done_total;
    nsteps = STEP_W'(2);
    start  = 1'b1;
    abort  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    abort  = 1'b0;
    check("t5_busy", 64'(busy), 64'(0));
    repeat (10) @(negedge clk);
    check("t5_npsen", 64'(psen_total - b_psen), 64'(0));
    check("t5_ndone", 64'(done_total - b_done), 64'(0));

    // Zero steps: done with no PSEN.
    start_sweep(1'b1, 0, 3, 0);
    wait_done("t6", 50);
    check("t6_npsen", 64'(psen_total - b_psen), 64'(0));
    check("t6_ndone", 64'(done_total - b_done), 64'(1));
    check("t6_nres", 64'(res_total - b_res), 64'(0));

    // Full-scale sample count, bits always 1: count 15 per RITC.
    scan_mode = 2;
    start_sweep(1'b1, 1, 15, 0);
    wait_done("t7", 200);
    expect_res(0, 'hFF);
    check_results("t7", 1);

    // nsamp 0 acts as 1 sample; no edge when already high at step 0.
    start_sweep(1'b1, 2, 0, 0);
    wait_done("t8", 200);
    expect_res(0, 'h11);
    expect_res(1, 'h11);
    check_results("t8", 2);
    check("t8_edge_valid", 64'(edge_valid), 64'(0));

    // Reset during SAMPLE, then a full sweep afterwards.
    start_sweep(1'b1, 2, 15, 0);
    wait_psen("t9", 50);
    repeat (8) @(negedge clk);
    check("t9_busy_pre", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("t9_async_clear", out_vec(), 64'(0));
    @(negedge clk);
    check("t9_held", out_vec(), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    start_sweep(1'b0, 2, 2, 1);
    wait_done("t9b", 200);
    check("t9b_npsen", 64'(psen_total - b_psen), 64'(2));
    check("t9b_ndone", 64'(done_total - b_done), 64'(1));
    expect_res(0, 'h22);
    expect_res(1, 'h22);
    check_results("t9b", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ritc_phase_scan_engine.md
RITC_PHASE_SCAN_ENGINE -- requirements
Module: ritc_phase_scan_engine

Interface
REQ-001 Parameter NUM_RITC, default 2: number of RITCs scanned in parallel, one selected scan bit each.
REQ-002 Parameter STEP_W, default 10: width of the step counter and of every step index.
REQ-003 Parameter SAMP_W, default 4: width of the per-step sample count and of each ones-counter.
REQ-004 Parameter PS_TIMEOUT, default 1023: maximum number of cycles to wait for PSDONE.
REQ-005 user_clk_i  in  1  sole clock; phase-shift control and all logic run on it.
REQ-006 user_rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-007 start_i  in  1  one-cycle sweep request.
REQ-008 abort_i  in  1  one-cycle abort request.
REQ-009 dir_i  in  1  PSINCDEC value for the sweep (1 = increment).
REQ-010 nsteps_i  in  STEP_W  number of phase steps to take.
REQ-011 nsamp_i  in  SAMP_W  samples taken per step; 0 is treated as 1.
REQ-012 settle_i  in  4  idle cycles between PSDONE and the first sample.
REQ-013 PSEN  out  1  phase-shift enable pulse.
REQ-014 PSINCDEC  out  1  phase-shift direction.
REQ-015 PSDONE  in  1  phase-shift complete, synchronous to user_clk_i.
REQ-016 scan_bit_i  in  NUM_RITC  selected, already-registered scan bit per RITC.
REQ-017 busy_o  out  1  high from sweep start until done.
REQ-018 done_o  out  1  one-cycle end-of-sweep pulse.
REQ-019 timeout_o  out  1  sticky flag set when a PSDONE wait times out.
REQ-020 res_wr_o  out  1  one-cycle result strobe, one per completed step.
REQ-021 res_step_o  out  STEP_W  index of the step reported by res_wr_o.
REQ-022 res_cnt_o  out  NUM_RITC*SAMP_W  ones-count per RITC, RITC k at [k*SAMP_W +: SAMP_W].
REQ-023 edge_valid_o  out  NUM_RITC  rising-edge found, per RITC.
REQ-024 edge_pos_o  out  NUM_RITC*STEP_W  first rising-edge step index per RITC.

Function
REQ-025 The FSM SHALL have states IDLE, STEP, WAIT_DONE, SETTLE, SAMPLE, REPORT and FINISH.
REQ-026 IDLE->STEP on start_i; start_i SHALL clear edge_valid_o, edge_pos_o, the step index and timeout_o, and latch dir_i, nsteps_i, nsamp_i and settle_i.
REQ-027 start_i with nsteps_i = 0 SHALL go IDLE->FINISH with no PSEN pulse.
REQ-028 STEP: assert PSEN for exactly 1 cycle, PSINCDEC = latched dir; go to WAIT_DONE; PSINCDEC SHALL hold its value until the next start.
REQ-029 WAIT_DONE->SETTLE on PSDONE; after PS_TIMEOUT cycles without PSDONE: set timeout_o, go FINISH.
REQ-030 SETTLE SHALL last settle_i cycles (0 = direct to SAMPLE) and then clear the ones-counters.
REQ-031 SAMPLE: take one sample per cycle for max(nsamp,1) cycles; each ones-counter adds scan_bit_i[k], saturating at 2^SAMP_W-1.
REQ-032 REPORT (1 cycle): pulse res_wr_o with res_step_o = current step and res_cnt_o = counts; res_cnt_o SHALL hold until the next REPORT.
REQ-033 Majority bit per RITC = (2*count > max(nsamp,1)).
REQ-034 Rising edge: majority 0 at step s-1 and 1 at step s, s >= 1; record s only if edge_valid_o[k] is 0, then set edge_valid_o[k]; later edges SHALL be ignored.
REQ-035 After REPORT: if step+1 == nsteps go to FINISH, else increment step and go to STEP.
REQ-036 FINISH: pulse done_o for 1 cycle, go to IDLE; busy_o SHALL be high in every state except IDLE.
REQ-037 start_i while busy SHALL be ignored.
REQ-038 abort_i in STEP, SETTLE, SAMPLE or REPORT SHALL go to FINISH next cycle with no further PSEN.
REQ-039 abort_i in WAIT_DONE SHALL be remembered and take effect on PSDONE or timeout, so a requested shift is never abandoned.
REQ-040 Simultaneous start_i and abort_i in IDLE: abort wins and the FSM stays in IDLE.

Reset
REQ-041 user_rst_n_i low SHALL immediately force IDLE and zero every output and counter, including mid-sweep; PSEN SHALL be 0 while reset is held.

Verification
REQ-042 nsteps=4, nsamp=3, settle=2, dir=1, PSDONE 5 cycles after each PSEN, scan_bit=0 -> 4 PSEN pulses; 4 res_wr_o with steps 0..3 and counts 0; done_o once; edge_valid_o=0.
REQ-043 RITC0 bit = 1 from step 2 onward, nsamp=4 -> counts 0,0,4,4; edge_pos_o[0]=2; edge_valid_o=01.
REQ-044 PSDONE never asserted -> timeout_o=1 exactly PS_TIMEOUT cycles after PSEN; done_o pulses; no res_wr_o.
REQ-045 abort_i during WAIT_DONE, PSDONE 3 cycles later -> no further PSEN; done_o pulses after PSDONE; busy_o falls.
REQ-046 nsteps=0 -> done_o pulses with no PSEN; nsamp=15 with bit always 1 -> count 15, no overflow.
REQ-047 user_rst_n_i pulsed low during SAMPLE -> all outputs 0 asynchronously; a new start_i after release runs a full sweep.
